ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_line_filter.sv | 60 ++++++
 rtl/ps2_key_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard decoder: the prefix FSM states, the
// scancode prefix bytes, the length of the Pause-key skip window, and the list
// of keyboard status/reply bytes that never map to a key event.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Bytes swallowed after E1 (the rest of the Pause make/break sequence).
    localparam logic [2:0] SKIP_LEN = 3'd7;

    // Keyboard replies / status codes that are not scancodes.
    localparam int         N_DISCARD    = 8;
    localparam logic [63:0] DISCARD_LIST = {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                            8'hFC, 8'hFD, 8'hFE, 8'hFF};

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_DISCARD; i++) begin
            if (DISCARD_LIST[i*8 +: 8] == b) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw PS/2 line into the clk_sys domain (2-FF synchronizer) and
// removes glitches: the filtered level only follows the synchronized level
// after it has differed for FILT_LEN consecutive cycles.
//
// Ports
//   clk_sys  in   system clock
//   res_n_i  in   asynchronous active-low reset (all flops reset to 1 = idle)
//   line_i   in   raw PS/2 line
//   line_o   out  synchronized, filtered line
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic res_n_i,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          filt_q,  filt_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        // Count consecutive cycles of disagreement; any agreement restarts it.
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard receiver and scancode-set-2 decoder. Both lines are
// synchronized and glitch filtered, 11-bit frames are shifted in on falling
// edges of the filtered clock, and good bytes run through a prefix FSM
// (E0 = extended, F0 = break, E1 = Pause sequence to skip) that produces one
// key event per key press/release.
//
// Ports
//   clk_sys       in   system clock (only clock)
//   res_n_i       in   asynchronous active-low reset
//   ps2_clk       in   raw PS/2 clock line
//   ps2_dat       in   raw PS/2 data line
//   key_strobe    out  one-cycle pulse per key event
//   key_pressed   out  1 = make, 0 = break
//   key_extended  out  1 = E0-prefixed key
//   key_code      out  scancode (set 2)
//   ps2_key       out  {toggle, pressed, extended, code}; toggle flips per event
//   frame_err     out  one-cycle pulse on parity or stop-bit error
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 20000
) (
    input  logic        clk_sys,
    input  logic        res_n_i,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        key_strobe,
    output logic        key_pressed,
    output logic        key_extended,
    output logic [7:0]  key_code,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_f;
    logic dat_f;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .res_n_i (res_n_i),
        .line_i  (ps2_clk),
        .line_o  (clk_f)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk_sys (clk_sys),
        .res_n_i (res_n_i),
        .line_i  (ps2_dat),
        .line_o  (dat_f)
    );

    logic          clk_prev_q, clk_prev_d;
    logic [3:0]    bit_cnt_q,  bit_cnt_d;
    logic [7:0]    shift_q,    shift_d;
    logic          par_ok_q,   par_ok_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    ps2_state_e    state_q,    state_d;
    logic [2:0]    skip_q,     skip_d;
    logic          strobe_q,   strobe_d;
    logic          ferr_q,     ferr_d;
    logic          pressed_q,  pressed_d;
    logic          ext_q,      ext_d;
    logic [7:0]    code_q,     code_d;
    logic          toggle_q,   toggle_d;

    logic fall;
    logic byte_vld;
    logic emit;
    logic ev_ext;
    logic ev_brk;

    assign fall = clk_prev_q & ~clk_f;

    // Frame receiver: bit_cnt 0 = waiting for start, 1..8 data, 9 parity, 10 stop.
    always_comb begin
        clk_prev_d = clk_f;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        to_cnt_d   = '0;
        ferr_d     = 1'b0;
        byte_vld   = 1'b0;

        // Mid-frame watchdog: a stalled frame is silently dropped.
        if (bit_cnt_q != 4'd0 && !fall) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = 4'd0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        if (fall) begin
            case (bit_cnt_q)
                4'd0: begin
                    if (!dat_f) bit_cnt_d = 4'd1;
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                    shift_d   = {dat_f, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                4'd9: begin
                    // Odd parity: data plus parity bit holds an odd count of ones.
                    par_ok_d  = ^{shift_q, dat_f};
                    ferr_d    = ~(^{shift_q, dat_f});
                    bit_cnt_d = 4'd10;
                end
                4'd10: begin
                    bit_cnt_d = 4'd0;
                    // A parity failure was already flagged; report only one error per frame.
                    if (par_ok_q) begin
                        if (dat_f) byte_vld = 1'b1;
                        else       ferr_d   = 1'b1;
                    end
                end
                default: bit_cnt_d = 4'd0;
            endcase
        end
    end

    // Prefix FSM and event outputs.
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        emit      = 1'b0;
        ev_ext    = 1'b0;
        ev_brk    = 1'b0;

        if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (shift_q == PFX_E0) begin
                        state_d = ST_EXT;
                    end else if (shift_q == PFX_F0) begin
                        state_d = ST_BRK;
                    end else if (shift_q == PFX_E1) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_LEN;
                    end else if (!is_discard(shift_q)) begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (shift_q == PFX_F0) begin
                        state_d = ST_EXT_BRK;
                    end else if (shift_q != PFX_E0) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (shift_q == PFX_E0) begin
                        state_d = ST_EXT_BRK;
                    end else if (shift_q != PFX_F0) begin
                        emit    = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (shift_q != PFX_E0 && shift_q != PFX_F0) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        ev_brk  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        strobe_d  = emit;
        pressed_d = emit ? ~ev_brk   : pressed_q;
        ext_d     = emit ? ev_ext    : ext_q;
        code_d    = emit ? shift_q   : code_q;
        toggle_d  = emit ? ~toggle_q : toggle_q;
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            to_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
            pressed_q  <= 1'b0;
            ext_q      <= 1'b0;
            code_q     <= '0;
            toggle_q   <= 1'b0;
        end else begin
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            skip_q     <= skip_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
            pressed_q  <= pressed_d;
            ext_q      <= ext_d;
            code_q     <= code_d;
            toggle_q   <= toggle_d;
        end
    end

    assign key_strobe   = strobe_q;
    assign frame_err    = ferr_q;
    assign key_pressed  = pressed_q;
    assign key_extended = ext_q;
    assign key_code     = code_q;
    assign ps2_key      = {toggle_q, pressed_q, ext_q, code_q};

endmodule
